prog_ctr_fetch: RTL and testbench
=================================

Name: prog_ctr_fetch

Overview:
- Program counter and fetch-sequencing stage; sits directly downstream of the branch-target lookup table.
- Drives the 2-bit table pointer from decode, consumes the 10-bit target the table returns, and produces the next instruction address.
- Run/halt FSM gives the testbench a start/done handshake.
- Retired-instruction counter is provided for performance checks.

Parameters:
- PC_W, 10, width of program counter and of the table target.
- START_PC, 10'h000, address loaded on every start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level; begins a program run.
- Stall  in  1  freeze PC and counter this cycle.
- Halt  in  1  decode saw halt instruction.
- BranchAbs  in  1  absolute jump: PC <= table target.
- BranchRel  in  1  relative branch request.
- Taken  in  1  ALU condition flag, qualifies BranchRel.
- BrSel  in  2  table pointer field from instruction.
- LutAddr  out  2  pointer to table; combinational copy of BrSel.
- Target  in  PC_W  table output (two's-complement offset or absolute address).
- ProgCtr  out  PC_W  current instruction address.
- Running  out  1  high in RUN.
- Done  out  1  high in HALT.
- InstCnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset low, asynchronous: state=IDLE, ProgCtr=START_PC, InstCnt=0, Running=0, Done=0. This holds mid-run too; the next activity requires Start after reset release.
- States are IDLE, RUN, HALT. Running and Done are registered decodes of state.
- IDLE: Start=1 -> RUN next edge; ProgCtr=START_PC, InstCnt=0. Otherwise hold.
- RUN: Start is ignored. Per-edge priority, exactly one action:
  1. Stall=1 -> hold ProgCtr, InstCnt, state. Halt and branches are ignored this cycle.
  2. Halt=1 -> state=HALT, ProgCtr holds, InstCnt+1.
  3. BranchAbs=1 -> ProgCtr=Target, InstCnt+1.
  4. BranchRel=1 and Taken=1 -> ProgCtr=ProgCtr+Target, modulo 2^PC_W with wrap in both directions (Target is sign-interpreted), InstCnt+1.
  5. Otherwise, including BranchRel=1 with Taken=0 -> ProgCtr=ProgCtr+1 (1023 wraps to 0), InstCnt+1.
- HALT: ProgCtr and InstCnt hold. Start=1 -> RUN with ProgCtr=START_PC and InstCnt=0, same as from IDLE.
- LutAddr = BrSel combinationally. The Target path is treated as same-cycle combinational; branch latency is 1 cycle (next-edge redirect, no bubble).
- InstCnt saturates at all-ones and does not wrap.
- BranchAbs and BranchRel both high: BranchAbs wins.
- Outside RUN, Halt, Stall and the branch inputs have no effect.

Test Plan:
- Reset low mid-run with ProgCtr=0x025 -> ProgCtr=0x000, InstCnt=0, Running=0 immediately without a clock edge. Start=1 after release -> RUN, ProgCtr=0x000.
- Sequential run: 5 plain cycles after start -> ProgCtr=0x005, InstCnt=5. ProgCtr=0x3FF plus one plain cycle -> 0x000.
- Relative branch: ProgCtr=0x010, BrSel=2'b00 (table returns 0x3FF), BranchRel=1, Taken=1 -> ProgCtr=0x00F. Same with Taken=0 -> 0x011. BrSel=2'b10 (0x007) taken from 0x3FC -> 0x003 (wrap).
- Absolute jump: BrSel=2'b01 (0x003), BranchAbs=1 together with BranchRel=1, Taken=1 -> ProgCtr=0x003. LutAddr tracks BrSel in the same cycle.
- Stall and halt: Stall=1 with Halt=1 at ProgCtr=0x020 -> ProgCtr, InstCnt and state unchanged. Next cycle Halt=1, Stall=0 -> Done=1, ProgCtr=0x020, InstCnt+1. Start=1 -> RUN, ProgCtr=0x000, InstCnt=0.
- Saturation: with CNT_W=4, 20 plain cycles -> InstCnt=4'hF and stays there.

Source files
------------

// File: rtl/prog_ctr_fetch.sv
// -----------------------------------------------------------------------------
// prog_ctr_fetch
//
// Purpose:
//   Program counter and fetch-sequencing stage. It sits directly after the
//   branch-target lookup table. It forwards the decode pointer to the table,
//   takes the table target back in the same cycle, and produces the next
//   instruction address. A small IDLE/RUN/HALT machine gives a start/done
//   handshake. A saturating counter tracks retired instructions.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   level; begins a program run from IDLE or HALT
//   stall      in   freeze PC, counter and state this cycle (RUN only)
//   halt       in   decode saw a halt instruction (RUN only)
//   branch_abs in   absolute jump, PC <= target (wins over branch_rel)
//   branch_rel in   relative branch request, qualified by taken
//   taken      in   ALU condition flag
//   br_sel     in   [1:0] table pointer field from the instruction
//   lut_addr   out  [1:0] pointer to the table, combinational copy of br_sel
//   target     in   [PC_W-1:0] table output (signed offset or absolute addr)
//   prog_ctr   out  [PC_W-1:0] current instruction address
//   running    out  high while in RUN (registered)
//   done       out  high while in HALT (registered)
//   inst_cnt   out  [CNT_W-1:0] retired-instruction count, saturating
// -----------------------------------------------------------------------------
module prog_ctr_fetch #(
   parameter int unsigned     PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = {PC_W{1'b0}},
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   input  logic             halt,
   input  logic             branch_abs,
   input  logic             branch_rel,
   input  logic             taken,
   input  logic [1:0]       br_sel,
   output logic [1:0]       lut_addr,
   input  logic [PC_W-1:0]  target,
   output logic [PC_W-1:0]  prog_ctr,
   output logic             running,
   output logic             done,
   output logic [CNT_W-1:0] inst_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t           state_r;
   logic [PC_W-1:0]  pc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             running_r;
   logic             done_r;

   logic [PC_W-1:0]  pc_step_s;
   logic [PC_W-1:0]  pc_rel_s;
   logic [PC_W-1:0]  pc_retire_s;
   logic [CNT_W-1:0] cnt_sat_s;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (&value) begin
         result = value;
      end else begin
         result = value + CNT_W'(1);
      end
      return result;
   endfunction

   // The table pointer is a straight pass-through so the target can return
   // within the same cycle.
   assign lut_addr = br_sel;

   // Address the PC moves to when the current instruction retires.
   // Both additions are naturally modulo 2^PC_W. A target with its top bit
   // set is a negative offset, so the relative path wraps in both directions.
   always_comb begin
      pc_step_s   = pc_r + PC_W'(1);
      pc_rel_s    = pc_r + target;
      pc_retire_s = pc_step_s;
      if (branch_abs) begin
         pc_retire_s = target;
      end else if (branch_rel && taken) begin
         pc_retire_s = pc_rel_s;
      end else begin
         pc_retire_s = pc_step_s;
      end
      cnt_sat_s = sat_inc(cnt_r);
   end

   // Run/halt sequencer, PC and counter. running and done are registered
   // together with each state change, so they always match the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pc_r      <= START_PC;
         cnt_r     <= {CNT_W{1'b0}};
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state_r   <= ST_RUN;
                  pc_r      <= START_PC;
                  cnt_r     <= {CNT_W{1'b0}};
                  running_r <= 1'b1;
                  done_r    <= 1'b0;
               end else begin
                  state_r   <= state_r;
                  pc_r      <= pc_r;
                  cnt_r     <= cnt_r;
                  running_r <= running_r;
                  done_r    <= done_r;
               end
            end
            ST_RUN: begin
               if (stall) begin
                  // Stall wins over everything, including halt.
                  state_r   <= ST_RUN;
                  pc_r      <= pc_r;
                  cnt_r     <= cnt_r;
                  running_r <= 1'b1;
                  done_r    <= 1'b0;
               end else if (halt) begin
                  // The halt instruction retires, but the PC stays on it.
                  state_r   <= ST_HALT;
                  pc_r      <= pc_r;
                  cnt_r     <= cnt_sat_s;
                  running_r <= 1'b0;
                  done_r    <= 1'b1;
               end else begin
                  state_r   <= ST_RUN;
                  pc_r      <= pc_retire_s;
                  cnt_r     <= cnt_sat_s;
                  running_r <= 1'b1;
                  done_r    <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               pc_r      <= START_PC;
               cnt_r     <= {CNT_W{1'b0}};
               running_r <= 1'b0;
               done_r    <= 1'b0;
            end
         endcase
      end
   end

   assign prog_ctr = pc_r;
   assign inst_cnt = cnt_r;
   assign running  = running_r;
   assign done     = done_r;

endmodule

// File: tb/tb_prog_ctr_fetch.sv
module tb_prog_ctr_fetch;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        halt;
   logic        branch_abs;
   logic        branch_rel;
   logic        taken;
   logic [1:0]  br_sel;
   logic [1:0]  lut_addr;
   logic [9:0]  target;
   logic [9:0]  prog_ctr;
   logic        running;
   logic        done;
   logic [15:0] inst_cnt;

   logic [1:0]  lut_addr_sat;
   logic [9:0]  target_sat;
   logic [9:0]  prog_ctr_sat;
   logic        running_sat;
   logic        done_sat;
   logic [3:0]  inst_cnt_sat;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Branch-target table contents seen by the fetch stage.
   function automatic logic [9:0] lut_f(input logic [1:0] a);
      case (a)
         2'b00:   return 10'h3FF;
         2'b01:   return 10'h003;
         2'b10:   return 10'h007;
         2'b11:   return 10'h010;
         default: return 10'h000;
      endcase
   endfunction

   assign target     = lut_f(lut_addr);
   assign target_sat = lut_f(lut_addr_sat);

   prog_ctr_fetch #(.PC_W(10), .START_PC(10'h000), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
      .branch_abs(branch_abs), .branch_rel(branch_rel), .taken(taken),
      .br_sel(br_sel), .lut_addr(lut_addr), .target(target),
      .prog_ctr(prog_ctr), .running(running), .done(done), .inst_cnt(inst_cnt)
   );

   prog_ctr_fetch #(.PC_W(10), .START_PC(10'h000), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
      .branch_abs(branch_abs), .branch_rel(branch_rel), .taken(taken),
      .br_sel(br_sel), .lut_addr(lut_addr_sat), .target(target_sat),
      .prog_ctr(prog_ctr_sat), .running(running_sat), .done(done_sat),
      .inst_cnt(inst_cnt_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 1'b0; stall = 1'b0; halt = 1'b0;
      branch_abs = 1'b0; branch_rel = 1'b0; taken = 1'b0; br_sel = 2'b00;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic plain(input int n);
      clear_inputs();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic abs_jump(input logic [1:0] sel);
      clear_inputs();
      br_sel = sel; branch_abs = 1'b1;
      tick();
      clear_inputs();
   endtask

   task automatic rel_branch(input logic [1:0] sel, input logic tk);
      clear_inputs();
      br_sel = sel; branch_rel = 1'b1; taken = tk;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #2;
      vec_cnt++; if (prog_ctr !== 10'h000) begin err_cnt++; $display("FAIL reset_pc: got %h expected %h", prog_ctr, 10'h000); end
      vec_cnt++; if (inst_cnt !== 16'h0000) begin err_cnt++; $display("FAIL reset_cnt: got %h expected %h", inst_cnt, 16'h0000); end
      vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL reset_running: got %b expected 0", running); end
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b expected 0", done); end
      rst_n = 1'b1;
      tick();
      // Idle: branch, halt and stall have no effect
      branch_abs = 1'b1; br_sel = 2'b11; halt = 1'b1;
      tick(); tick();
      clear_inputs();
      vec_cnt++; if (prog_ctr !== 10'h000) begin err_cnt++; $display("FAIL idle_pc: got %h expected %h", prog_ctr, 10'h000); end
      vec_cnt++; if (running !== 1'b0 || done !== 1'b0) begin err_cnt++; $display("FAIL idle_state: got run=%b done=%b expected 0 0", running, done); end
      vec_cnt++; if (inst_cnt !== 16'h0000) begin err_cnt++; $display("FAIL idle_cnt: got %h expected %h", inst_cnt, 16'h0000); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      start_run();
      abs_jump(2'b11);          // 0x010
      rel_branch(2'b11, 1'b1);  // 0x020
      plain(5);                 // 0x025
      vec_cnt++; if (prog_ctr !== 10'h025) begin err_cnt++; $display("FAIL midrun_setup_pc: got %h expected %h", prog_ctr, 10'h025); end
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++; if (prog_ctr !== 10'h000) begin err_cnt++; $display("FAIL midrun_rst_pc: got %h expected %h", prog_ctr, 10'h000); end
      vec_cnt++; if (inst_cnt !== 16'h0000) begin err_cnt++; $display("FAIL midrun_rst_cnt: got %h expected %h", inst_cnt, 16'h0000); end
      vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL midrun_rst_running: got %b expected 0", running); end
      #2;
      rst_n = 1'b1;
      tick();
      vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL post_rst_no_start: got %b expected 0", running); end
      start_run();
      vec_cnt++; if (running !== 1'b1 || prog_ctr !== 10'h000) begin err_cnt++; $display("FAIL restart: got run=%b pc=%h expected 1 000", running, prog_ctr); end
   endtask

   task automatic test_sequential();
      do_reset();
      start_run();
      vec_cnt++; if (prog_ctr !== 10'h000 || inst_cnt !== 16'h0000) begin err_cnt++; $display("FAIL start_state: got pc=%h cnt=%h expected 000 0000", prog_ctr, inst_cnt); end
      plain(5);
      vec_cnt++; if (prog_ctr !== 10'h005) begin err_cnt++; $display("FAIL seq_pc: got %h expected %h", prog_ctr, 10'h005); end
      vec_cnt++; if (inst_cnt !== 16'd5) begin err_cnt++; $display("FAIL seq_cnt: got %0d expected 5", inst_cnt); end
      abs_jump(2'b00);          // 0x3FF
      vec_cnt++; if (prog_ctr !== 10'h3FF) begin err_cnt++; $display("FAIL seq_to_3ff: got %h expected %h", prog_ctr, 10'h3FF); end
      plain(1);
      vec_cnt++; if (prog_ctr !== 10'h000) begin err_cnt++; $display("FAIL seq_wrap: got %h expected %h", prog_ctr, 10'h000); end
      vec_cnt++; if (inst_cnt !== 16'd7) begin err_cnt++; $display("FAIL seq_wrap_cnt: got %0d expected 7", inst_cnt); end
      // Start is ignored while running
      start = 1'b1;
      tick();
      start = 1'b0;
      vec_cnt++; if (prog_ctr !== 10'h001) begin err_cnt++; $display("FAIL start_in_run: got %h expected %h", prog_ctr, 10'h001); end
   endtask

   task automatic test_rel_branch();
      do_reset();
      start_run();
      abs_jump(2'b11);          // 0x010
      rel_branch(2'b00, 1'b1);  // -1
      vec_cnt++; if (prog_ctr !== 10'h00F) begin err_cnt++; $display("FAIL rel_taken_neg: got %h expected %h", prog_ctr, 10'h00F); end
      abs_jump(2'b11);
      rel_branch(2'b00, 1'b0);
      vec_cnt++; if (prog_ctr !== 10'h011) begin err_cnt++; $display("FAIL rel_not_taken: got %h expected %h", prog_ctr, 10'h011); end
      abs_jump(2'b00);          // 0x3FF
      rel_branch(2'b00, 1'b1);
      rel_branch(2'b00, 1'b1);
      rel_branch(2'b00, 1'b1);  // 0x3FC
      vec_cnt++; if (prog_ctr !== 10'h3FC) begin err_cnt++; $display("FAIL rel_to_3fc: got %h expected %h", prog_ctr, 10'h3FC); end
      rel_branch(2'b10, 1'b1);  // +7 wraps
      vec_cnt++; if (prog_ctr !== 10'h003) begin err_cnt++; $display("FAIL rel_wrap_fwd: got %h expected %h", prog_ctr, 10'h003); end
      rel_branch(2'b00, 1'b1);  // 0x002
      rel_branch(2'b00, 1'b1);  // 0x001
      rel_branch(2'b00, 1'b1);  // 0x000
      rel_branch(2'b00, 1'b1);  // wraps back to 0x3FF
      vec_cnt++; if (prog_ctr !== 10'h3FF) begin err_cnt++; $display("FAIL rel_wrap_back: got %h expected %h", prog_ctr, 10'h3FF); end
      vec_cnt++; if (inst_cnt !== 16'd13) begin err_cnt++; $display("FAIL rel_cnt: got %0d expected 13", inst_cnt); end
   endtask

   task automatic test_abs_jump();
      do_reset();
      start_run();
      plain(2);                 // 0x002
      br_sel = 2'b01; branch_abs = 1'b1; branch_rel = 1'b1; taken = 1'b1;
      #1;
      vec_cnt++; if (lut_addr !== 2'b01) begin err_cnt++; $display("FAIL lut_addr_01: got %b expected 01", lut_addr); end
      tick();
      clear_inputs();
      vec_cnt++; if (prog_ctr !== 10'h003) begin err_cnt++; $display("FAIL abs_over_rel: got %h expected %h", prog_ctr, 10'h003); end
      br_sel = 2'b10;
      #1;
      vec_cnt++; if (lut_addr !== 2'b10) begin err_cnt++; $display("FAIL lut_addr_10: got %b expected 10", lut_addr); end
      br_sel = 2'b11;
      #1;
      vec_cnt++; if (lut_addr !== 2'b11) begin err_cnt++; $display("FAIL lut_addr_11: got %b expected 11", lut_addr); end
      clear_inputs();
   endtask

   task automatic test_stall_halt();
      do_reset();
      start_run();
      abs_jump(2'b11);          // 0x010, cnt 1
      plain(16);                // 0x020, cnt 17
      stall = 1'b1; halt = 1'b1; branch_abs = 1'b1; br_sel = 2'b01;
      tick();
      vec_cnt++; if (prog_ctr !== 10'h020 || inst_cnt !== 16'd17) begin err_cnt++; $display("FAIL stall_hold: got pc=%h cnt=%0d expected 020 17", prog_ctr, inst_cnt); end
      vec_cnt++; if (running !== 1'b1 || done !== 1'b0) begin err_cnt++; $display("FAIL stall_state: got run=%b done=%b expected 1 0", running, done); end
      stall = 1'b0;             // halt still high, branch_abs too: halt wins
      tick();
      clear_inputs();
      vec_cnt++; if (done !== 1'b1 || running !== 1'b0) begin err_cnt++; $display("FAIL halt_state: got run=%b done=%b expected 0 1", running, done); end
      vec_cnt++; if (prog_ctr !== 10'h020 || inst_cnt !== 16'd18) begin err_cnt++; $display("FAIL halt_pc_cnt: got pc=%h cnt=%0d expected 020 18", prog_ctr, inst_cnt); end
      branch_abs = 1'b1; br_sel = 2'b11;
      tick(); tick();
      clear_inputs();
      vec_cnt++; if (prog_ctr !== 10'h020 || inst_cnt !== 16'd18 || done !== 1'b1) begin err_cnt++; $display("FAIL halt_hold: got pc=%h cnt=%0d done=%b expected 020 18 1", prog_ctr, inst_cnt, done); end
      start_run();
      vec_cnt++; if (running !== 1'b1 || done !== 1'b0) begin err_cnt++; $display("FAIL halt_restart_state: got run=%b done=%b expected 1 0", running, done); end
      vec_cnt++; if (prog_ctr !== 10'h000 || inst_cnt !== 16'd0) begin err_cnt++; $display("FAIL halt_restart_pc_cnt: got pc=%h cnt=%0d expected 000 0", prog_ctr, inst_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      start_run();
      plain(15);
      vec_cnt++; if (inst_cnt_sat !== 4'hF) begin err_cnt++; $display("FAIL sat_reach: got %h expected F", inst_cnt_sat); end
      plain(5);
      vec_cnt++; if (inst_cnt_sat !== 4'hF) begin err_cnt++; $display("FAIL sat_hold: got %h expected F", inst_cnt_sat); end
      vec_cnt++; if (prog_ctr_sat !== 10'h014) begin err_cnt++; $display("FAIL sat_pc: got %h expected %h", prog_ctr_sat, 10'h014); end
      vec_cnt++; if (inst_cnt !== 16'd20) begin err_cnt++; $display("FAIL wide_cnt: got %0d expected 20", inst_cnt); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_run();
      test_sequential();
      test_rel_branch();
      test_abs_jump();
      test_stall_halt();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
